lk_route_ovc_flit_updater: RTL and testbench
============================================

// Module: lk_route_ovc_flit_updater
// PURPOSE
// - Router output-stage flit rewriter: stamps the granted output VC into every flit.
// - In a header flit, also replaces the destination-port field with the look-ahead route for the next hop.
// - Selects per-VC data using the input VC registered one cycle earlier, which aligns with the switch-allocation pipeline.
// - Adaptive mesh/torus mode re-encodes the dest field using a per-VC adaptive select bit.
// PARAMETERS
// V          4      number of VCs; one-hot VC fields are V bits wide
// P          5      router port count; informational only
// Fw         38     flit width; FPAYw = Fw-2-V (32 at defaults)
// DSTPw      4      destination-port field width
// DST_P_LSB  8      LSB of the dest field in the flit; DST_P_MSB = DST_P_LSB+DSTPw-1
// SSA_EN     0      1 = bypass the registered look-ahead when no IVC was granted last cycle
// MULTI_FLIT 1      1 = header flag is flit[Fw-1]; 0 = every flit is a header
// ADAPTIVE   0      1 = adaptive dest encoder (requires DSTPw==4); 0 = dest_coded = lk_dest
// PORTS
// clk              in   1        clock; all state updates on the rising edge
// reset            in   1        synchronous, active-high
// flit_in          in   Fw       {hdr,tail,vc[V],payload[FPAYw]}
// flit_out         out  Fw       rewritten flit (combinational)
// vc_num_in        in   V        one-hot input VC of the flit being switched this cycle
// lk_dest_all_in   in   V*DSTPw  per-VC look-ahead dest; slice i = [i*DSTPw +: DSTPw]
// assigned_ovc_num in   V*V      per-IVC assigned OVC (one-hot); slice i = [i*V +: V]
// sel              in   V        per-IVC adaptive select bit (ADAPTIVE only)
// any_ivc_sw_request_granted in 1  any IVC won the switch this cycle (SSA_EN only)
// lk_dest_not_registered     in DSTPw  look-ahead dest used on the SSA bypass path
// BEHAVIOUR
// - Clocking and reset: one clock (clk); reset is synchronous and active-high.
// - vc_d <= reset ? 0 : vc_num_in.
// - any_d <= reset ? 0 : any_ivc_sw_request_granted (register exists only when SSA_EN=1).
// - One-hot mux: Q = OR over i of (D[i] & {W{sel[i]}}).
//   - Zero select gives Q = 0.
//   - Multiple select bits give the OR of the selected slices; no error is flagged.
// - lk_mux = mux(lk_dest_all_in, vc_d); ovc = mux(assigned_ovc_num, vc_d).
// - Look-ahead select: lk_dest = (SSA_EN && !any_d) ? lk_dest_not_registered : lk_mux.
// - Adaptive encode: s = mux(sel, vc_d); f = flit_in dest field.
//   - s=1: dest_coded = {lk_dest[3:2], f[1:0]}.
//   - s=0: dest_coded = {f[3:2], lk_dest[1:0]}.
//   - Non-adaptive: dest_coded = lk_dest.
// - Output assembly: flit_out = {flit_in[Fw-1:Fw-2], ovc, flit_in[FPAYw-1:0]}.
//   - If hdr (flit_in[Fw-1], or always 1 when MULTI_FLIT=0), flit_out[DST_P_MSB:DST_P_LSB] = dest_coded.
//   - Body and tail flits keep their dest bits; only the VC field changes.
// - Latency: flit_in to flit_out is 0 cycles; vc_num_in takes effect 1 cycle later.
// - After reset: vc_d=0, so ovc=0 and lk_mux=0.
//   - A header flit then gets VC field 0 and dest 0, or lk_dest_not_registered when SSA_EN=1.
// - Reset asserted mid-stream: registers clear on the next edge; the combinational path keeps following flit_in.
// - No handshake: the caller qualifies the output with its own write strobe.
// STRUCTURE
// - Shared package: flag positions (HDR=Fw-1, TAIL=Fw-2), FPAYw function, dest-field MSB/LSB.
// - Sub-modules: generic onehot_mux_1d (W,N), used three times.
// - Sub-module: reset-to-zero register noc_dff (W).
// - Adaptive encoder kept in a small generate block, not a separate module.
// TESTING (V=4, Fw=38, DST_P_LSB=8, DSTPw=4)
// 1 Reset: reset=1 for 1 cycle, header flit_in dest=4'hF -> flit_out VC field=0, dest=0.
// 2 Non-adaptive header: cycle N vc_num_in=4'b0100; cycle N+1 lk slice2=4'hA, ovc slice2=4'b0001, header in
//   -> flit_out[35:32]=4'b0001, flit_out[11:8]=4'hA, payload otherwise unchanged.
// 3 Body flit (hdr=0) with same setup -> VC field=4'b0001, flit_out[11:8]=flit_in[11:8].
// 4 ADAPTIVE=1, vc_d=4'b0010, sel=4'b0010, lk_dest=4'b1001, f=4'b0110 -> dest=4'b1010;
//   same with sel=0 -> dest=4'b0101.
// 5 SSA_EN=1, any_ivc_sw_request_granted=0 last cycle, lk_dest_not_registered=4'h3 -> dest=4'h3;
//   granted=1 last cycle -> dest = registered slice.
// 6 MULTI_FLIT=0: flit_in[37]=0 -> dest is still replaced.

Source files
------------

// File: rtl/lk_route_ovc_flit_updater_pkg.sv
// Shared definitions for the look-ahead route / output-VC flit rewriter.
// Flit layout: {hdr, tail, vc[V], payload[FPAYw]}, with the destination-port
// field living inside the payload.
package lk_route_ovc_flit_updater_pkg;

  // Distinguishes flits whose dest field gets rewritten from those that pass through
  typedef enum logic {
    FLIT_BODY   = 1'b0,
    FLIT_HEADER = 1'b1
  } flit_kind_e;

  // Payload width left after the two flag bits and the one-hot VC field
  function automatic int fpayWidth(input int fw, input int v);
    return fw - 2 - v;
  endfunction

  // Header flag sits in the top bit of the flit
  function automatic int hdrPos(input int fw);
    return fw - 1;
  endfunction

  // Tail flag sits just below the header flag
  function automatic int tailPos(input int fw);
    return fw - 2;
  endfunction

  // Top bit of the destination-port field
  function automatic int dstMsb(input int lsb, input int w);
    return lsb + w - 1;
  endfunction

endpackage

// File: rtl/lk_route_ovc_flit_updater_lib.sv
// Small building blocks used by the flit rewriter: a one-hot mux over N
// slices of W bits, and a plain register that clears on synchronous reset.

module onehot_mux_1d #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic [W*N-1:0] i_d,
  input  logic [N-1:0]   i_sel,
  output logic [W-1:0]   o_q
);

  // OR together every slice whose select bit is set; no select gives zero
  always_comb begin
    o_q = '0;
    for (int i = 0; i < N; i++) begin
      o_q = o_q | (i_d[i*W +: W] & {W{i_sel[i]}});
    end
  end

endmodule

module noc_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture the input every cycle, clearing to zero while reset is high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lk_route_ovc_flit_updater.sv
// Output-stage flit rewriter. Every flit gets the granted output VC stamped
// into its VC field; header flits also get their dest-port field replaced by
// the look-ahead route for the next hop. The per-VC tables are indexed by the
// input VC captured one cycle earlier, lining up with switch allocation.
module lk_route_ovc_flit_updater
  import lk_route_ovc_flit_updater_pkg::*;
#(
  parameter int V          = 4,
  parameter int P          = 5,
  parameter int Fw         = 38,
  parameter int DSTPw      = 4,
  parameter int DST_P_LSB  = 8,
  parameter int SSA_EN     = 0,
  parameter int MULTI_FLIT = 1,
  parameter int ADAPTIVE   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Fw-1:0]        flit_in,
  output logic [Fw-1:0]        flit_out,
  input  logic [V-1:0]         vc_num_in,
  input  logic [V*DSTPw-1:0]   lk_dest_all_in,
  input  logic [V*V-1:0]       assigned_ovc_num,
  input  logic [V-1:0]         sel,
  input  logic                 any_ivc_sw_request_granted,
  input  logic [DSTPw-1:0]     lk_dest_not_registered
);

  localparam int FPAYW = fpayWidth(Fw, V);
  localparam int HDR   = hdrPos(Fw);
  localparam int TAIL  = tailPos(Fw);
  localparam int DMSB  = dstMsb(DST_P_LSB, DSTPw);

  logic [V-1:0]     w_vc_d;
  logic [DSTPw-1:0] w_lk_mux;
  logic [DSTPw-1:0] w_lk_dest;
  logic [DSTPw-1:0] w_dest_field;
  logic [DSTPw-1:0] w_dest_coded;
  logic [V-1:0]     w_ovc;
  flit_kind_e       w_kind;
  logic             w_unused_ok;

  // Input VC of the flit being switched, delayed to match the allocator pipeline
  noc_dff #(.W(V)) u_vc_reg (
    .clk   (clk),
    .reset (reset),
    .i_d   (vc_num_in),
    .o_q   (w_vc_d)
  );

  onehot_mux_1d #(.W(DSTPw), .N(V)) u_lk_mux (
    .i_d   (lk_dest_all_in),
    .i_sel (w_vc_d),
    .o_q   (w_lk_mux)
  );

  onehot_mux_1d #(.W(V), .N(V)) u_ovc_mux (
    .i_d   (assigned_ovc_num),
    .i_sel (w_vc_d),
    .o_q   (w_ovc)
  );

  // With single-cycle switch allocation, a cycle without any grant means the
  // registered look-ahead is stale and the unregistered one must be used
  if (SSA_EN != 0) begin : g_ssa
    logic w_any_d;

    noc_dff #(.W(1)) u_any_reg (
      .clk   (clk),
      .reset (reset),
      .i_d   (any_ivc_sw_request_granted),
      .o_q   (w_any_d)
    );

    assign w_lk_dest = w_any_d ? w_lk_mux : lk_dest_not_registered;
  end else begin : g_no_ssa
    assign w_lk_dest = w_lk_mux;
  end

  assign w_dest_field = flit_in[DMSB:DST_P_LSB];

  // Adaptive routing splits the dest field in two halves; the per-VC select
  // bit decides which half comes from the look-ahead and which is kept
  if (ADAPTIVE != 0) begin : g_adaptive
    logic w_sel_d;

    onehot_mux_1d #(.W(1), .N(V)) u_sel_mux (
      .i_d   (sel),
      .i_sel (w_vc_d),
      .o_q   (w_sel_d)
    );

    assign w_dest_coded = w_sel_d ? {w_lk_dest[DSTPw-1:2], w_dest_field[1:0]}
                                  : {w_dest_field[DSTPw-1:2], w_lk_dest[1:0]};
  end else begin : g_static
    assign w_dest_coded = w_lk_dest;
  end

  // Without multi-flit packets every flit carries its own route
  assign w_kind = ((MULTI_FLIT != 0) && !flit_in[HDR]) ? FLIT_BODY : FLIT_HEADER;

  // Rebuild the flit with the new VC, then overwrite the dest field on headers
  always_comb begin
    flit_out = {flit_in[HDR:TAIL], w_ovc, flit_in[FPAYW-1:0]};
    if (w_kind == FLIT_HEADER) begin
      flit_out[DMSB:DST_P_LSB] = w_dest_coded;
    end
  end

  // Inputs that only matter in some configurations, plus the incoming VC field
  assign w_unused_ok = ^{flit_in[TAIL-1 -: V], sel, any_ivc_sw_request_granted,
                         lk_dest_not_registered, 32'(P)};

endmodule

// File: tb/tb_lk_route_ovc_flit_updater.sv
// Bench for the flit rewriter. Three configurations are driven with the same
// stimulus: static routing, adaptive routing, and single-cycle allocation
// with single-flit packets. Expected flits are queued as stimulus is issued
// and a monitor compares them whenever the write strobe is up.
module tb_lk_route_ovc_flit_updater;

  localparam int V     = 4;
  localparam int Fw    = 38;
  localparam int DSTPw = 4;

  typedef struct packed {
    logic [Fw-1:0] expBase;
    logic [Fw-1:0] expAdapt;
    logic [Fw-1:0] expSsa;
    logic [15:0]   tag;
  } expect_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [Fw-1:0]    flitIn;
  logic [V-1:0]     vcNumIn;
  logic [V*DSTPw-1:0] lkAll;
  logic [V*V-1:0]   ovcAll;
  logic [V-1:0]     selIn;
  logic             anyGnt;
  logic [DSTPw-1:0] lkNotReg;
  logic             stb;
  logic [Fw-1:0]    flitOutBase;
  logic [Fw-1:0]    flitOutAdapt;
  logic [Fw-1:0]    flitOutSsa;

  expect_t scoreQ[$];
  int errors = 0;
  int checks = 0;

  logic [V-1:0] prevVc;
  logic         prevAny;

  always #5 clk = ~clk;

  lk_route_ovc_flit_updater #(
    .V(V), .P(5), .Fw(Fw), .DSTPw(DSTPw), .DST_P_LSB(8),
    .SSA_EN(0), .MULTI_FLIT(1), .ADAPTIVE(0)
  ) dutBase (
    .clk(clk), .reset(reset), .flit_in(flitIn), .flit_out(flitOutBase),
    .vc_num_in(vcNumIn), .lk_dest_all_in(lkAll), .assigned_ovc_num(ovcAll),
    .sel(selIn), .any_ivc_sw_request_granted(anyGnt),
    .lk_dest_not_registered(lkNotReg)
  );

  lk_route_ovc_flit_updater #(
    .V(V), .P(5), .Fw(Fw), .DSTPw(DSTPw), .DST_P_LSB(8),
    .SSA_EN(0), .MULTI_FLIT(1), .ADAPTIVE(1)
  ) dutAdapt (
    .clk(clk), .reset(reset), .flit_in(flitIn), .flit_out(flitOutAdapt),
    .vc_num_in(vcNumIn), .lk_dest_all_in(lkAll), .assigned_ovc_num(ovcAll),
    .sel(selIn), .any_ivc_sw_request_granted(anyGnt),
    .lk_dest_not_registered(lkNotReg)
  );

  lk_route_ovc_flit_updater #(
    .V(V), .P(5), .Fw(Fw), .DSTPw(DSTPw), .DST_P_LSB(8),
    .SSA_EN(1), .MULTI_FLIT(0), .ADAPTIVE(0)
  ) dutSsa (
    .clk(clk), .reset(reset), .flit_in(flitIn), .flit_out(flitOutSsa),
    .vc_num_in(vcNumIn), .lk_dest_all_in(lkAll), .assigned_ovc_num(ovcAll),
    .sel(selIn), .any_ivc_sw_request_granted(anyGnt),
    .lk_dest_not_registered(lkNotReg)
  );

  // Pick table entries for every VC flagged in the one-hot (or multi-hot) vector
  function automatic logic [3:0] pickSlices(input logic [15:0] table4, input logic [3:0] vcs);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (vcs[i]) acc = acc | table4[i*4 +: 4];
    end
    return acc;
  endfunction

  // Reference behaviour: what the output stage should emit for one flit
  function automatic logic [Fw-1:0] modelFlit(
    input bit adaptive, input bit ssa, input bit multiFlit,
    input logic [Fw-1:0] f, input logic [3:0] pv, input logic pa,
    input logic [15:0] lk, input logic [15:0] ovcTab,
    input logic [3:0] selv, input logic [3:0] lknr);
    logic [Fw-1:0] res;
    logic [3:0] route;
    logic [3:0] oldDest;
    logic [3:0] newDest;
    bit useAdaptHigh;
    bit isHeader;
    res = f;
    res[35:32] = pickSlices(ovcTab, pv);
    route = (ssa && !pa) ? lknr : pickSlices(lk, pv);
    oldDest = f[11:8];
    useAdaptHigh = ((selv & pv) != 4'h0);
    if (!adaptive)         newDest = route;
    else if (useAdaptHigh) newDest = {route[3:2], oldDest[1:0]};
    else                   newDest = {oldDest[3:2], route[1:0]};
    isHeader = multiFlit ? f[37] : 1'b1;
    if (isHeader) res[11:8] = newDest;
    return res;
  endfunction

  // One clock of stimulus: advance the model's view of last cycle, drive, queue expectation
  task automatic applyStimulus(
    input logic rst, input logic [Fw-1:0] f, input logic [3:0] vc,
    input logic [15:0] lk, input logic [15:0] ovcTab, input logic [3:0] selv,
    input logic gnt, input logic [3:0] lknr, input bit check, input int tag);
    expect_t e;
    @(posedge clk);
    prevVc  = reset ? 4'h0 : vcNumIn;
    prevAny = reset ? 1'b0 : anyGnt;
    #1;
    reset    = rst;
    flitIn   = f;
    vcNumIn  = vc;
    lkAll    = lk;
    ovcAll   = ovcTab;
    selIn    = selv;
    anyGnt   = gnt;
    lkNotReg = lknr;
    stb      = check;
    if (check) begin
      e.expBase  = modelFlit(1'b0, 1'b0, 1'b1, f, prevVc, prevAny, lk, ovcTab, selv, lknr);
      e.expAdapt = modelFlit(1'b1, 1'b0, 1'b1, f, prevVc, prevAny, lk, ovcTab, selv, lknr);
      e.expSsa   = modelFlit(1'b0, 1'b1, 1'b0, f, prevVc, prevAny, lk, ovcTab, selv, lknr);
      e.tag      = 16'(tag);
      scoreQ.push_back(e);
    end
  endtask

  // Compare one DUT output against its queued expectation
  task automatic checkOutput(input string name, input int tag,
                             input logic [Fw-1:0] actual, input logic [Fw-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s tag=%0d actual=%h expected=%h", name, tag, actual, expected);
    end
  endtask

  // Monitor: whenever the strobe qualifies the outputs, pop and compare
  always @(negedge clk) begin
    if (stb === 1'b1) begin
      if (scoreQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty actual=0 expected=1 entries");
      end else begin
        expect_t e;
        e = scoreQ.pop_front();
        checkOutput("base",  int'(e.tag), flitOutBase,  e.expBase);
        checkOutput("adapt", int'(e.tag), flitOutAdapt, e.expAdapt);
        checkOutput("ssa",   int'(e.tag), flitOutSsa,   e.expSsa);
      end
    end
  end

  function automatic logic [Fw-1:0] mkFlit(input logic hdr, input logic tail,
                                          input logic [3:0] vc, input logic [31:0] pay);
    return {hdr, tail, vc, pay};
  endfunction

  initial begin
    logic [63:0] rnd;
    logic [3:0]  rvc;
    int          waitCycles;
    reset = 1'b1; flitIn = '0; vcNumIn = '0; lkAll = '0; ovcAll = '0;
    selIn = '0; anyGnt = 1'b0; lkNotReg = '0; stb = 1'b0;
    prevVc = '0; prevAny = 1'b0;

    // Reset, then a header with dest F right after it
    applyStimulus(1'b1, mkFlit(1, 0, 4'h5, 32'h1234_5F78), 4'b0100, 16'hABCD, 16'h8421,
                  4'hF, 1'b1, 4'h7, 1'b0, 0);
    applyStimulus(1'b1, mkFlit(1, 0, 4'h5, 32'h1234_5F78), 4'b0100, 16'hABCD, 16'h8421,
                  4'hF, 1'b1, 4'h7, 1'b0, 0);
    applyStimulus(1'b0, mkFlit(1, 0, 4'h5, 32'h1234_5F78), 4'b0100, 16'hABCD, 16'h8421,
                  4'hF, 1'b1, 4'h7, 1'b1, 1);

    // Non-adaptive header through VC 2, then a body flit with the same setup
    applyStimulus(1'b0, mkFlit(1, 0, 4'h3, 32'hDEAD_B5EF), 4'b0100, 16'h0A00, 16'h0100,
                  4'h0, 1'b1, 4'h6, 1'b1, 2);
    applyStimulus(1'b0, mkFlit(0, 1, 4'h3, 32'hCAFE_F7D0), 4'b0100, 16'h0A00, 16'h0100,
                  4'h0, 1'b1, 4'h6, 1'b1, 3);

    // Adaptive split with sel set, then cleared, on VC 1
    applyStimulus(1'b0, mkFlit(1, 0, 4'h1, 32'h0000_0600), 4'b0010, 16'h0090, 16'h0080,
                  4'b0010, 1'b1, 4'h0, 1'b1, 40);
    applyStimulus(1'b0, mkFlit(1, 0, 4'h1, 32'h0000_0600), 4'b0010, 16'h0090, 16'h0080,
                  4'b0010, 1'b0, 4'h3, 1'b1, 4);
    applyStimulus(1'b0, mkFlit(1, 0, 4'h1, 32'h0000_0600), 4'b0010, 16'h0090, 16'h0080,
                  4'b0000, 1'b1, 4'h3, 1'b1, 41);

    // Bypass route after a cycle with no grant, registered route after a grant,
    // with non-header flits so the single-flit instance still rewrites dest
    applyStimulus(1'b0, mkFlit(0, 0, 4'h2, 32'h5555_5A55), 4'b0010, 16'h00C0, 16'h0020,
                  4'b0000, 1'b0, 4'h3, 1'b1, 5);
    applyStimulus(1'b0, mkFlit(0, 0, 4'h2, 32'h5555_5A55), 4'b0010, 16'h00C0, 16'h0020,
                  4'b0000, 1'b1, 4'h3, 1'b1, 6);
    applyStimulus(1'b0, mkFlit(0, 0, 4'h2, 32'h5555_5A55), 4'b0010, 16'h00C0, 16'h0020,
                  4'b0000, 1'b1, 4'h3, 1'b1, 60);

    // Randomized traffic including multi-hot/zero VCs and occasional mid-stream reset
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       rvc = 4'($urandom_range(0, 15));
        1:       rvc = 4'h0;
        default: rvc = 4'(1 << $urandom_range(0, 3));
      endcase
      applyStimulus(($urandom_range(0, 39) == 0), rnd[Fw-1:0], rvc,
                    16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                    4'($urandom), 1'b1, 100 + n);
    end

    // Drain: stop strobing and give the monitor a bounded time to empty the queue
    applyStimulus(1'b0, '0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b0, 4'h0, 1'b0, 0);
    waitCycles = 0;
    while (scoreQ.size() != 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (scoreQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d expected=0 pending", scoreQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
